// File: rtl/pkg_tpu.sv
// Shared TPU types and constants: the instruction word and default instruction buffer depth.
package pkg_tpu;

  localparam int INSTR_BUF_DEPTH = 64;

  typedef struct packed {
    logic        v;
    logic [6:0]  opcode;
    logic [23:0] operand;
  } instr_t;

endpackage

// File: rtl/instr_buffer_if.sv
// Loader/fetch bus of the instruction buffer; slave is the buffer, master drives it.
interface instr_buffer_if #(
  parameter int DEPTH = pkg_tpu::INSTR_BUF_DEPTH
);
  import pkg_tpu::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             I_Clr;
  logic             I_We;
  instr_t           I_Instr;
  logic             O_Full;
  logic             O_Almost_Full;
  logic             O_Ovf;
  logic             I_Re;
  logic             O_Empty;
  instr_t           O_Instr;
  logic [CNT_W-1:0] O_Count;

  modport slave (
    input  I_Clr, I_We, I_Instr, I_Re,
    output O_Full, O_Almost_Full, O_Ovf, O_Empty, O_Instr, O_Count
  );

  modport master (
    output I_Clr, I_We, I_Instr, I_Re,
    input  O_Full, O_Almost_Full, O_Ovf, O_Empty, O_Instr, O_Count
  );

endinterface

// File: rtl/instr_buffer_ram.sv
// Simple dual-port instruction store: one write port, one registered read port (read-first).
module instr_buffer_ram #(
  parameter int DEPTH = pkg_tpu::INSTR_BUF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clock,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  pkg_tpu::instr_t wdata,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output pkg_tpu::instr_t rdata
);
  import pkg_tpu::*;

  instr_t mem [DEPTH];
  instr_t rdata_reg;

  // Same-address read and write returns the old word, which the full-buffer read+write relies on.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_reg <= mem[raddr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/instr_buffer.sv
// Instruction FIFO feeding the scalar-unit fetch stage: pointers, occupancy and flags around a BRAM store.
module instr_buffer #(
  parameter int DEPTH    = pkg_tpu::INSTR_BUF_DEPTH,
  parameter int AFULL_TH = DEPTH - 4
) (
  input logic           clock,
  input logic           reset,
  instr_buffer_if.slave bus
);
  import pkg_tpu::*;

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [AW-1:0]    wptr_reg, rptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             ovf_reg;
  logic             rd_valid_reg;
  logic             full, empty;
  logic             wr_ok, rd_ok, wr_drop;
  instr_t           ram_rdata;

  // Flags decode only from the count register, never from the inputs.
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);

  assign rd_ok   = bus.I_Re & ~empty & ~bus.I_Clr;
  assign wr_ok   = bus.I_We & bus.I_Instr.v & (~full | rd_ok) & ~bus.I_Clr;
  assign wr_drop = bus.I_We & bus.I_Instr.v & full & ~rd_ok & ~bus.I_Clr;

  always_comb begin
    count_next = count_reg;
    if (wr_ok && !rd_ok)      count_next = count_reg + 1'b1;
    else if (rd_ok && !wr_ok) count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset || bus.I_Clr) begin
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      count_reg    <= '0;
      ovf_reg      <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      if (wr_ok) wptr_reg <= wptr_reg + 1'b1;
      if (rd_ok) rptr_reg <= rptr_reg + 1'b1;
      count_reg    <= count_next;
      rd_valid_reg <= rd_ok;
      if (wr_drop) ovf_reg <= 1'b1;
    end
  end

  instr_buffer_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clock (clock),
    .we    (wr_ok & ~reset),
    .waddr (wptr_reg),
    .wdata (bus.I_Instr),
    .re    (rd_ok & ~reset),
    .raddr (rptr_reg),
    .rdata (ram_rdata)
  );

  // Read data is presented only in the cycle after an accepted read, so v never repeats.
  assign bus.O_Instr       = rd_valid_reg ? ram_rdata : '0;
  assign bus.O_Full        = full;
  assign bus.O_Empty       = empty;
  assign bus.O_Almost_Full = (count_reg >= CNT_W'(AFULL_TH));
  assign bus.O_Ovf         = ovf_reg;
  assign bus.O_Count       = count_reg;

endmodule
